// File: rtl/parking_gate_arbiter_pkg.sv
// Shared definitions for the parking gate arbiter: FSM encodings, grant
// directions and the default gate timing for a 50 MHz clock.
package parking_gate_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPEN_IN  = 2'd1,
    ST_OPEN_OUT = 2'd2,
    ST_CLOSING  = 2'd3
  } state_t;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_t;

  // 100 ms passage window and 20 ms closing guard at 50 MHz
  localparam int DEF_TMR_W        = 24;
  localparam int DEF_OPEN_CYCLES  = 5_000_000;
  localparam int DEF_CLOSE_CYCLES = 1_000_000;

  function automatic logic is_open(input state_t s);
    return (s == ST_OPEN_IN) || (s == ST_OPEN_OUT);
  endfunction

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Request, sensor-event, occupancy and barrier-command signals exchanged
// between the gate arbiter and its surroundings.
interface parking_gate_arbiter_if #(
  parameter int CNT_W = 4
);
  logic             req_in;
  logic             req_out;
  logic             evt_entry;
  logic             evt_exit;
  logic [CNT_W-1:0] car_count;
  logic             gate_open;
  logic             grant_in;
  logic             grant_out;
  logic             full;
  logic             deny_in;
  logic             err_tmo;
  logic             err_dir;

  modport master (
    output req_in, req_out, evt_entry, evt_exit, car_count,
    input  gate_open, grant_in, grant_out, full, deny_in, err_tmo, err_dir
  );

  modport slave (
    input  req_in, req_out, evt_entry, evt_exit, car_count,
    output gate_open, grant_in, grant_out, full, deny_in, err_tmo, err_dir
  );
endinterface

// File: rtl/parking_gate_arbiter_gate_timer.sv
// Loadable down-counter shared by the open window and the closing guard.
// Stops at zero instead of wrapping.
module gate_timer #(
  parameter int TMR_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - TMR_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Grants the single barrier to entry or exit, holds it open until the
// matching passage or a timeout, then enforces a closing guard time.
module parking_gate_arbiter
  import parking_gate_arbiter_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int CAPACITY     = 15,
  parameter int TMR_W        = DEF_TMR_W,
  parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input logic                  clk,
  input logic                  reset,
  parking_gate_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CAP_VAL    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLOSE_LOAD = TMR_W'(CLOSE_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  dir_t             last_grant;
  logic             pend_in;
  logic             pend_out;
  logic             take_in;
  logic             take_out;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             tmo_next;
  logic             dir_err_next;

  gate_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (state != ST_IDLE),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Registered FSM state, request latches, round-robin pointer and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      last_grant    <= DIR_OUT;
      pend_in       <= 1'b0;
      pend_out      <= 1'b0;
      bus.gate_open <= 1'b0;
      bus.grant_in  <= 1'b0;
      bus.grant_out <= 1'b0;
      bus.full      <= 1'b0;
      bus.deny_in   <= 1'b0;
      bus.err_tmo   <= 1'b0;
      bus.err_dir   <= 1'b0;
    end else begin
      state <= state_next;
      // A request arriving on the grant edge re-arms its latch
      pend_in  <= (pend_in & ~take_in) | (bus.req_in & ~bus.full);
      pend_out <= (pend_out & ~take_out) | bus.req_out;
      if (take_in) begin
        last_grant <= DIR_IN;
      end else if (take_out) begin
        last_grant <= DIR_OUT;
      end
      bus.gate_open <= is_open(state_next);
      bus.grant_in  <= (state_next == ST_OPEN_IN);
      bus.grant_out <= (state_next == ST_OPEN_OUT);
      bus.full      <= (bus.car_count >= CAP_VAL);
      bus.deny_in   <= bus.req_in & bus.full;
      bus.err_tmo   <= tmo_next;
      bus.err_dir   <= dir_err_next;
    end
  end

  // Next-state selection, grant arbitration and timer reload requests
  always_comb begin
    state_next   = state;
    take_in      = 1'b0;
    take_out     = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmo_next     = 1'b0;
    dir_err_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pend_in && pend_out) begin
          if (bus.full || (last_grant == DIR_IN)) begin
            take_out = 1'b1;
          end else begin
            take_in = 1'b1;
          end
        end else if (pend_out) begin
          take_out = 1'b1;
        end else if (pend_in && !bus.full) begin
          take_in = 1'b1;
        end
        if (take_in || take_out) begin
          state_next = take_in ? ST_OPEN_IN : ST_OPEN_OUT;
          tmr_load   = 1'b1;
          tmr_val    = OPEN_LOAD;
        end
      end

      ST_OPEN_IN, ST_OPEN_OUT: begin
        // A passage event beats a simultaneous timeout
        if ((state == ST_OPEN_IN) ? bus.evt_entry : bus.evt_exit) begin
          state_next = ST_CLOSING;
        end else if ((state == ST_OPEN_IN) ? bus.evt_exit : bus.evt_entry) begin
          state_next   = ST_CLOSING;
          dir_err_next = 1'b1;
        end else if (tmr_zero) begin
          state_next = ST_CLOSING;
          tmo_next   = 1'b1;
        end
        if (state_next == ST_CLOSING) begin
          tmr_load = 1'b1;
          tmr_val  = CLOSE_LOAD;
        end
      end

      ST_CLOSING: begin
        if (tmr_zero) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
